// File: rtl/trace_ring_buffer.sv
// trace_ring_buffer: captures per-core instruction trace records into a line RAM.
// Each active cycle packs one line (4 words per core), buffers it in a skid FIFO
// and writes it into a dual-port line RAM. Supports stop-on-full or circular mode,
// a fill threshold stall request, drop accounting and a 32-bit word read-back port.
module trace_ring_buffer #(
  parameter int unsigned NB_CORES   = 4,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned LW = $clog2(NB_CORES * 16),
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                     ref_clk_i,
  input  logic                     rst_ni,
  input  logic                     fetch_en_i,
  input  logic                     cg_clken_i,
  input  logic [NB_CORES*64-1:0]   instr_trace_cycles_i,
  input  logic [NB_CORES*32-1:0]   instr_trace_instr_i,
  input  logic [NB_CORES*32-1:0]   instr_trace_pc_i,
  input  logic [NB_CORES-1:0]      instr_trace_valid_i,
  input  logic [NB_CORES-1:0]      core_mask_i,
  input  logic                     mode_i,
  input  logic [AW:0]              threshold_i,
  input  logic                     trace_flushed_i,
  output logic                     trace_wait_o,
  input  logic                     rd_en_i,
  input  logic [31:0]              rd_addr_i,
  output logic [31:0]              rd_data_o,
  output logic                     rd_valid_o,
  output logic [AW-1:0]            wr_ptr_o,
  output logic [AW:0]              fill_o,
  output logic                     wrapped_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int unsigned NW  = NB_CORES * 4;
  localparam int unsigned WW  = LW - 2;
  localparam int unsigned FAW = $clog2(FIFO_DEPTH);
  localparam int unsigned FPW = FAW + 1;
  localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  typedef logic [NW-1:0][31:0] line_t;

  // input register stage
  logic [NB_CORES-1:0][59:0] cycles_d, cycles_q;
  logic [NB_CORES-1:0][31:0] instr_d, instr_q;
  logic [NB_CORES-1:0][31:0] pc_d, pc_q;
  logic [NB_CORES-1:0]       valid_d, valid_q;
  logic                      unused_cycles_c;

  // packed line, skid FIFO and line RAM
  line_t          line_c;
  line_t          fifo_mem [FIFO_DEPTH];
  line_t          ram_mem  [DEPTH];
  logic [FPW-1:0] fifo_wp_d, fifo_wp_q;
  logic [FPW-1:0] fifo_rp_d, fifo_rp_q;

  // control and status
  logic           fifo_empty_c, fifo_full_c;
  logic           clear_c, at_full_c, pop_c, push_req_c, push_c, drop_c;
  logic [AW-1:0]  wr_ptr_d, wr_ptr_q;
  logic [AW:0]    fill_d, fill_q;
  logic           wrapped_d, wrapped_q;
  logic [15:0]    drop_cnt_d, drop_cnt_q;
  logic           wait_d, wait_q;

  // read port
  logic [AW-1:0]  rd_line_c;
  logic [WW-1:0]  rd_word_c;
  logic [31:0]    rd_data_d, rd_data_q;
  logic           rd_valid_d, rd_valid_q;
  logic           unused_addr_c;

  // Split the flat trace buses per core and apply the capture mask.
  always_comb begin
    unused_cycles_c = 1'b0;
    cycles_d        = '0;
    instr_d         = '0;
    pc_d            = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      cycles_d[i]     = instr_trace_cycles_i[i*64 +: 60];
      instr_d[i]      = instr_trace_instr_i[i*32 +: 32];
      pc_d[i]         = instr_trace_pc_i[i*32 +: 32];
      unused_cycles_c = unused_cycles_c ^ (^instr_trace_cycles_i[i*64+60 +: 4]);
    end
    valid_d = instr_trace_valid_i & core_mask_i;
  end

  // Register all trace inputs every cycle.
  always_ff @(posedge ref_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= '0;
      instr_q  <= '0;
      pc_q     <= '0;
      valid_q  <= '0;
    end else begin
      cycles_q <= cycles_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
    end
  end

  // Pack one record line: cycles low, {valid, cycles high}, instr, pc per core.
  always_comb begin
    line_c = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      line_c[4*i+0] = cycles_q[i][31:0];
      line_c[4*i+1] = {valid_q[i], 3'b000, cycles_q[i][59:32]};
      line_c[4*i+2] = instr_q[i];
      line_c[4*i+3] = pc_q[i];
    end
  end

  // Push/pop decisions, pointer and counter next-state.
  always_comb begin
    fifo_empty_c = (fifo_wp_q == fifo_rp_q);
    fifo_full_c  = (fifo_wp_q[FAW] != fifo_rp_q[FAW]) &&
                   (fifo_wp_q[FAW-1:0] == fifo_rp_q[FAW-1:0]);
    clear_c      = trace_flushed_i | ~fetch_en_i;
    at_full_c    = (fill_q == FILL_MAX);
    pop_c        = ~fifo_empty_c & ~(~mode_i & at_full_c) & ~clear_c;
    push_req_c   = (|valid_q) & cg_clken_i & fetch_en_i & ~trace_flushed_i;
    push_c       = push_req_c & (~fifo_full_c | pop_c);
    drop_c       = push_req_c & fifo_full_c & ~pop_c;

    fifo_wp_d  = fifo_wp_q;
    fifo_rp_d  = fifo_rp_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    wrapped_d  = wrapped_q;
    drop_cnt_d = drop_cnt_q;
    wait_d     = wait_q;

    if (push_c) fifo_wp_d = fifo_wp_q + FPW'(1);
    if (pop_c) begin
      fifo_rp_d = fifo_rp_q + FPW'(1);
      wr_ptr_d  = wr_ptr_q + AW'(1);
      if (at_full_c) wrapped_d = 1'b1;
      else           fill_d    = fill_q + (AW+1)'(1);
    end
    if (drop_c && (drop_cnt_q != DROP_MAX)) drop_cnt_d = drop_cnt_q + 16'd1;

    // Stall request is sticky in stop mode, frozen while capture is disabled.
    if (trace_flushed_i)  wait_d = 1'b0;
    else if (mode_i)      wait_d = 1'b0;
    else if (fetch_en_i)  wait_d = wait_q | (fill_q >= threshold_i);

    if (clear_c) begin
      fifo_wp_d = '0;
      fifo_rp_d = '0;
      wr_ptr_d  = '0;
      fill_d    = '0;
      wrapped_d = 1'b0;
    end
    if (trace_flushed_i) drop_cnt_d = '0;
  end

  // Control state registers.
  always_ff @(posedge ref_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_wp_q  <= '0;
      fifo_rp_q  <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      wrapped_q  <= 1'b0;
      drop_cnt_q <= '0;
      wait_q     <= 1'b0;
    end else begin
      fifo_wp_q  <= fifo_wp_d;
      fifo_rp_q  <= fifo_rp_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      wrapped_q  <= wrapped_d;
      drop_cnt_q <= drop_cnt_d;
      wait_q     <= wait_d;
    end
  end

  // Skid FIFO storage; contents need no reset, pointers define validity.
  always_ff @(posedge ref_clk_i) begin
    if (push_c) fifo_mem[fifo_wp_q[FAW-1:0]] <= line_c;
  end

  // Line RAM write port; contents survive reset.
  always_ff @(posedge ref_clk_i) begin
    if (pop_c) ram_mem[wr_ptr_q] <= fifo_mem[fifo_rp_q[FAW-1:0]];
  end

  // Read address decode and read-first word select.
  always_comb begin
    rd_line_c     = rd_addr_i[AW+LW-1:LW];
    rd_word_c     = rd_addr_i[LW-1:2];
    unused_addr_c = ^{rd_addr_i[31:AW+LW], rd_addr_i[1:0]};
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_en_i;
    if (rd_en_i) rd_data_d = ram_mem[rd_line_c][rd_word_c];
  end

  // Read data and single-cycle valid pulse.
  always_ff @(posedge ref_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign trace_wait_o = wait_q;
  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign wr_ptr_o     = wr_ptr_q;
  assign fill_o       = fill_q;
  assign wrapped_o    = wrapped_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_trace_ring_buffer.sv
// Bench for trace_ring_buffer (4 cores, 16-line RAM, 4-entry FIFO):
// queue-based reference model compared every cycle plus directed literal checks.
module tb_trace_ring_buffer;

  localparam int unsigned NBC = 4;
  localparam int unsigned DEP = 16;
  localparam int unsigned FD  = 4;

  typedef logic [15:0][31:0] line_t;

  logic          ref_clk_i = 1'b0;
  logic          rst_ni;
  logic          fetch_en_i, cg_clken_i;
  logic [255:0]  cyc;
  logic [127:0]  instr, pc;
  logic [3:0]    valid, mask;
  logic          mode;
  logic [4:0]    thr;
  logic          flush;
  logic          trace_wait;
  logic          rd_en;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [3:0]    wr_ptr;
  logic [4:0]    fill;
  logic          wrapped;
  logic [15:0]   drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  trace_ring_buffer #(.NB_CORES(NBC), .DEPTH(DEP), .FIFO_DEPTH(FD)) dut (
    .ref_clk_i            (ref_clk_i),
    .rst_ni               (rst_ni),
    .fetch_en_i           (fetch_en_i),
    .cg_clken_i           (cg_clken_i),
    .instr_trace_cycles_i (cyc),
    .instr_trace_instr_i  (instr),
    .instr_trace_pc_i     (pc),
    .instr_trace_valid_i  (valid),
    .core_mask_i          (mask),
    .mode_i               (mode),
    .threshold_i          (thr),
    .trace_flushed_i      (flush),
    .trace_wait_o         (trace_wait),
    .rd_en_i              (rd_en),
    .rd_addr_i            (rd_addr),
    .rd_data_o            (rd_data),
    .rd_valid_o           (rd_valid),
    .wr_ptr_o             (wr_ptr),
    .fill_o               (fill),
    .wrapped_o            (wrapped),
    .drop_cnt_o           (drop_cnt)
  );

  always #5 ref_clk_i = ~ref_clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  line_t    mq[$];
  line_t    mram [DEP];
  bit       mknown [DEP];
  int       m_fill, m_wp, m_drop;
  bit       m_wrap, m_wait, m_rdv, m_rd_known;
  logic [31:0]  m_rd;
  logic [3:0]   p_valid;
  logic [255:0] p_cyc;
  logic [127:0] p_instr, p_pc;

  initial for (int i = 0; i < DEP; i++) mknown[i] = 1'b0;

  function automatic line_t mk_line();
    line_t l;
    for (int i = 0; i < 4; i++) begin
      l[4*i+0] = p_cyc[64*i +: 32];
      l[4*i+1] = {p_valid[i], 3'b000, p_cyc[64*i+32 +: 28]};
      l[4*i+2] = p_instr[32*i +: 32];
      l[4*i+3] = p_pc[32*i +: 32];
    end
    return l;
  endfunction

  task automatic model_step();
    bit pop, push_req, full_pre, at_full;
    int ln, wd;
    if (!rst_ni) begin
      mq.delete();
      m_fill = 0; m_wp = 0; m_drop = 0;
      m_wrap = 0; m_wait = 0; m_rdv = 0; m_rd = '0; m_rd_known = 1;
      p_valid = '0; p_cyc = '0; p_instr = '0; p_pc = '0;
      return;
    end
    // read-first: sample RAM before this cycle's write
    m_rdv = rd_en;
    if (rd_en) begin
      ln = int'(rd_addr[9:6]);
      wd = int'(rd_addr[5:2]);
      m_rd = mram[ln][wd];
      m_rd_known = mknown[ln];
    end
    full_pre = (mq.size() == FD);
    at_full  = (m_fill == DEP);
    pop      = (mq.size() > 0) && !(!mode && at_full) && !flush && fetch_en_i;
    push_req = (|p_valid) && cg_clken_i && fetch_en_i && !flush;
    if (flush)           m_wait = 0;
    else if (mode)       m_wait = 0;
    else if (fetch_en_i) m_wait = m_wait | (m_fill >= int'(thr));
    if (pop) begin
      if (at_full) m_wrap = 1;
      mram[m_wp]   = mq.pop_front();
      mknown[m_wp] = 1'b1;
      m_wp = (m_wp + 1) % DEP;
      if (m_fill < DEP) m_fill++;
    end
    if (push_req) begin
      if (full_pre && !pop) begin
        if (m_drop < 16'hFFFF) m_drop++;
      end else mq.push_back(mk_line());
    end
    if (flush) m_drop = 0;
    if (flush || !fetch_en_i) begin
      mq.delete(); m_wp = 0; m_fill = 0; m_wrap = 0;
    end
    p_valid = valid & mask; p_cyc = cyc; p_instr = instr; p_pc = pc;
  endtask

  // Advance the model on each edge, compare just after it.
  always @(posedge ref_clk_i) begin
    model_step();
    #1;
    chk("m_fill",    64'(fill),       64'(m_fill));
    chk("m_wr_ptr",  64'(wr_ptr),     64'(m_wp));
    chk("m_wrapped", 64'(wrapped),    64'(m_wrap));
    chk("m_drop",    64'(drop_cnt),   64'(m_drop));
    chk("m_wait",    64'(trace_wait), 64'(m_wait));
    chk("m_rdvalid", 64'(rd_valid),   64'(m_rdv));
    if (m_rdv && m_rd_known) chk("m_rddata", 64'(rd_data), 64'(m_rd));
  end

  // ---------------- stimulus helpers ----------------
  task automatic rec(input int r);
    valid = 4'b0001;
    cyc[63:0]   = 64'(r);
    instr[31:0] = 32'h100 + 32'(r);
    pc[31:0]    = 32'h1C00_0000 + 32'(r);
  endtask

  task automatic idle();
    valid = '0; cyc = '0; instr = '0; pc = '0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(negedge ref_clk_i);
    flush = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    @(negedge ref_clk_i);
    rd_en = 1'b0;
    chk("rd_valid_pulse", 64'(rd_valid), 64'd1);
    d = rd_data;
  endtask

  task automatic wait_fill(input int target, input string nm, inout int r);
    int guard = 0;
    while (int'(fill) != target && guard < 100) begin
      @(negedge ref_clk_i); r++; rec(r); guard++;
    end
    if (guard >= 100) chk({nm, "_timeout"}, 64'(fill), 64'(target));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    int r;
    rst_ni = 1'b0; fetch_en_i = 1'b1; cg_clken_i = 1'b1;
    cyc = '0; instr = '0; pc = '0; valid = '0; mask = 4'hF;
    mode = 1'b0; thr = 5'd31; flush = 1'b0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge ref_clk_i);
    chk("reset_fill",  64'(fill), 64'd0);
    chk("reset_wptr",  64'(wr_ptr), 64'd0);
    chk("reset_wait",  64'(trace_wait), 64'd0);
    chk("reset_rdval", 64'(rd_valid), 64'd0);
    rst_ni = 1'b1;
    @(negedge ref_clk_i);

    // single record on core 2
    cyc[191:128] = 64'h0000_0001_2345_6789;
    instr[95:64] = 32'h0000_0013;
    pc[95:64]    = 32'h1C00_0080;
    valid        = 4'b0100;
    @(negedge ref_clk_i); idle();
    @(negedge ref_clk_i);
    chk("single_fill_early", 64'(fill), 64'd0);
    @(negedge ref_clk_i);
    chk("single_fill", 64'(fill), 64'd1);
    chk("single_wptr", 64'(wr_ptr), 64'd1);
    rd(32'h28, d); chk("rd_instr", 64'(d), 64'h0000_0013);
    rd(32'h24, d); chk("rd_cyc_hi", 64'(d), 64'h8000_0001);
    rd(32'h2C, d); chk("rd_pc", 64'(d), 64'h1C00_0080);
    rd(32'h20, d); chk("rd_cyc_lo", 64'(d), 64'h2345_6789);
    rd(32'h08, d); chk("rd_core0_bit31", 64'(d[31]), 64'd0);
    @(negedge ref_clk_i);
    chk("rd_valid_single", 64'(rd_valid), 64'd0);

    // mask filtering
    flush_pulse();
    mask = 4'b0001;
    valid = 4'b1000;
    repeat (10) @(negedge ref_clk_i);
    idle();
    repeat (3) @(negedge ref_clk_i);
    chk("mask_fill", 64'(fill), 64'd0);
    chk("mask_drop", 64'(drop_cnt), 64'd0);
    mask = 4'hF;

    // stop mode, threshold 10, continuous records
    thr = 5'd10; mode = 1'b0;
    r = 1; rec(r);
    wait_fill(10, "stop_fill10", r);
    chk("wait_at_fill10", 64'(trace_wait), 64'd0);
    @(negedge ref_clk_i); r++; rec(r);
    chk("wait_after_fill10", 64'(trace_wait), 64'd1);
    wait_fill(16, "stop_fill16", r);
    repeat (3) begin @(negedge ref_clk_i); r++; rec(r); end
    chk("stop_drop0", 64'(drop_cnt), 64'd0);
    @(negedge ref_clk_i); r++; rec(r);
    chk("stop_drop1", 64'(drop_cnt), 64'd1);
    @(negedge ref_clk_i); r++; rec(r);
    chk("stop_drop2", 64'(drop_cnt), 64'd2);
    chk("stop_fill_sat", 64'(fill), 64'd16);

    // flush coinciding with a pending push
    flush = 1'b1; idle();
    @(negedge ref_clk_i); flush = 1'b0;
    chk("flush_fill", 64'(fill), 64'd0);
    chk("flush_wptr", 64'(wr_ptr), 64'd0);
    chk("flush_drop", 64'(drop_cnt), 64'd0);
    chk("flush_wait", 64'(trace_wait), 64'd0);
    repeat (3) @(negedge ref_clk_i);
    chk("flush_fifo_empty", 64'(fill), 64'd0);

    // circular mode, 20 records, read-first on line 3
    mode = 1'b1;
    for (int k = 1; k <= 20; k++) begin rec(k); @(negedge ref_clk_i); end
    idle();
    @(negedge ref_clk_i);
    rd_en = 1'b1; rd_addr = 32'hC0;
    @(negedge ref_clk_i); rd_en = 1'b0;
    chk("rf_valid", 64'(rd_valid), 64'd1);
    chk("rf_old_data", 64'(rd_data), 64'd4);
    repeat (3) @(negedge ref_clk_i);
    chk("circ_wptr", 64'(wr_ptr), 64'd4);
    chk("circ_fill", 64'(fill), 64'd16);
    chk("circ_wrapped", 64'(wrapped), 64'd1);
    chk("circ_wait", 64'(trace_wait), 64'd0);
    rd(32'h00, d); chk("circ_line0", 64'(d), 64'd17);
    rd(32'h04, d); chk("circ_line0_w1", 64'(d), 64'h8000_0000);
    rd(32'hC0, d); chk("circ_line3_new", 64'(d), 64'd20);

    // fetch_en low clears fill/pointer/wrap but holds drops
    fetch_en_i = 1'b0;
    @(negedge ref_clk_i); fetch_en_i = 1'b1;
    chk("fe_fill", 64'(fill), 64'd0);
    chk("fe_wrapped", 64'(wrapped), 64'd0);

    // clock gate low: nothing captured
    cg_clken_i = 1'b0;
    rec(99);
    repeat (5) @(negedge ref_clk_i);
    idle();
    repeat (3) @(negedge ref_clk_i);
    cg_clken_i = 1'b1;
    chk("cg_fill", 64'(fill), 64'd0);

    // reset with the FIFO holding three entries
    mode = 1'b0;
    flush_pulse();
    for (int k = 1; k <= 19; k++) begin rec(k); @(negedge ref_clk_i); end
    idle();
    @(negedge ref_clk_i);
    chk("pre_reset_fill", 64'(fill), 64'd16);
    chk("pre_reset_wait", 64'(trace_wait), 64'd1);
    rst_ni = 1'b0;
    @(negedge ref_clk_i);
    chk("mid_reset_fill", 64'(fill), 64'd0);
    chk("mid_reset_wptr", 64'(wr_ptr), 64'd0);
    chk("mid_reset_wait", 64'(trace_wait), 64'd0);
    chk("mid_reset_rddata", 64'(rd_data), 64'd0);
    rst_ni = 1'b1;
    repeat (5) @(negedge ref_clk_i);
    chk("post_reset_nowrite", 64'(fill), 64'd0);
    valid = 4'b0010; cyc[127:64] = 64'd7;
    @(negedge ref_clk_i); idle();
    repeat (2) @(negedge ref_clk_i);
    chk("post_reset_write", 64'(fill), 64'd1);

    // threshold 0 raises wait immediately after reset release
    rst_ni = 1'b0; thr = 5'd0;
    @(negedge ref_clk_i);
    chk("thr0_in_reset", 64'(trace_wait), 64'd0);
    rst_ni = 1'b1;
    @(negedge ref_clk_i);
    chk("thr0_wait", 64'(trace_wait), 64'd1);

    repeat (2) @(negedge ref_clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
